// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer of {PC, instruction} pairs between fetch and decode.
// Define FETCH_QUEUE_BYPASS_EN for a zero-latency empty-queue bypass from enq_* to deq_*.
module fetch_queue #(
   parameter int ADDR_WIDTH  = 12,
   parameter int INSTR_WIDTH = 32,
   parameter int DEPTH       = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     enq_valid,
   output logic                     enq_ready,
   input  logic [ADDR_WIDTH-1:0]    enq_pc,
   input  logic [INSTR_WIDTH-1:0]   enq_instr,
   output logic                     deq_valid,
   input  logic                     deq_ready,
   output logic [ADDR_WIDTH-1:0]    deq_pc,
   output logic [INSTR_WIDTH-1:0]   deq_instr,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic [ADDR_WIDTH-1:0]  pc_mem_q    [DEPTH];
   logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];

   logic byp;
   logic enq_fire, deq_fire;
   logic wr_en, rd_en;

`ifdef FETCH_QUEUE_BYPASS_EN
   // Reset gating keeps deq_valid low while the queue is held in reset.
   assign byp = reset_n && !flush && (count_q == '0) && enq_valid;
`else
   assign byp = 1'b0;
`endif

   assign enq_ready = reset_n && (count_q != FULL);
   assign deq_valid = (count_q != '0) || byp;
   assign count     = count_q;

   assign enq_fire = enq_valid && enq_ready;
   assign deq_fire = deq_valid && deq_ready;

   // A bypassed entry that decode takes immediately never touches storage.
   assign wr_en = enq_fire && !(byp && deq_ready);
   assign rd_en = deq_fire && !byp;

   always_comb begin
      deq_pc    = '0;
      deq_instr = '0;
      if (byp) begin
         deq_pc    = enq_pc;
         deq_instr = enq_instr;
      end else if (count_q != '0) begin
         deq_pc    = pc_mem_q[rd_ptr_q];
         deq_instr = instr_mem_q[rd_ptr_q];
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en, rd_en})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (reset_n && !flush && wr_en) begin
         pc_mem_q[wr_ptr_q]    <= enq_pc;
         instr_mem_q[wr_ptr_q] <= enq_instr;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: scoreboard monitor plus per-scenario directed tasks.
module tb_fetch_queue;

   localparam int AW = 12;
   localparam int IW = 32;
   localparam int D  = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n, flush, enq_valid, deq_ready;
   logic          enq_ready, deq_valid;
   logic [AW-1:0] enq_pc, deq_pc;
   logic [IW-1:0] enq_instr, deq_instr;
   logic [2:0]    count;

   int n_pass  = 0;
   int n_total = 0;
   bit mon_en  = 1'b0;

   logic [AW+IW-1:0] sb [$];

   fetch_queue #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(D)) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush),
      .enq_valid(enq_valid), .enq_ready(enq_ready),
      .enq_pc(enq_pc), .enq_instr(enq_instr),
      .deq_valid(deq_valid), .deq_ready(deq_ready),
      .deq_pc(deq_pc), .deq_instr(deq_instr),
      .count(count)
   );

   always #5 clk = ~clk;

   // Scoreboard monitor: the model's occupancy is the queue size before this cycle's edge.
   always @(negedge clk) begin
      logic [AW+IW-1:0] exp_e;
      bit exp_ready, exp_valid;
      if (mon_en) begin
         if (!reset_n) begin
            if (enq_ready !== 1'b0) $display("FAIL mon_rst_ready got %b exp 0", enq_ready);
            else n_pass++;
            n_total++;
            sb.delete();
         end else begin
            exp_ready = (sb.size() < D);
            exp_valid = (sb.size() != 0) || (BYP && enq_valid && !flush);
            if (count !== 3'(sb.size())) $display("FAIL mon_count got %0d exp %0d", count, sb.size());
            else n_pass++;
            n_total++;
            if (enq_ready !== exp_ready) $display("FAIL mon_enq_ready got %b exp %b", enq_ready, exp_ready);
            else n_pass++;
            n_total++;
            if (deq_valid !== exp_valid) $display("FAIL mon_deq_valid got %b exp %b", deq_valid, exp_valid);
            else n_pass++;
            n_total++;
            if (flush) begin
               sb.delete();
            end else begin
               if (enq_valid && exp_ready) sb.push_back({enq_pc, enq_instr});
               if (deq_ready && exp_valid && sb.size() != 0) begin
                  exp_e = sb.pop_front();
                  if ({deq_pc, deq_instr} !== exp_e)
                     $display("FAIL mon_deq_data got %h/%h exp %h/%h", deq_pc, deq_instr, exp_e[AW+IW-1:IW], exp_e[IW-1:0]);
                  else n_pass++;
                  n_total++;
               end else if (!exp_valid) begin
                  if ({deq_pc, deq_instr} !== '0) $display("FAIL mon_idle_data got %h/%h exp 0/0", deq_pc, deq_instr);
                  else n_pass++;
                  n_total++;
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      enq_valid = 1'b0;
      deq_ready = 1'b1;
      repeat (D + 2) cyc();
      deq_ready = 1'b0;
      if (count !== 3'd0) $display("FAIL drain_count got %0d exp 0", count);
      else n_pass++;
      n_total++;
      if (deq_valid !== 1'b0) $display("FAIL drain_valid got %b exp 0", deq_valid);
      else n_pass++;
      n_total++;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
      enq_pc = '0; enq_instr = '0;
      cyc();
      mon_en = 1'b1;
      cyc();
      if (count !== 3'd0) $display("FAIL rst_count got %0d exp 0", count);
      else n_pass++;
      n_total++;
      if (deq_valid !== 1'b0) $display("FAIL rst_deq_valid got %b exp 0", deq_valid);
      else n_pass++;
      n_total++;
      if (deq_pc !== '0) $display("FAIL rst_deq_pc got %h exp 0", deq_pc);
      else n_pass++;
      n_total++;
      if (enq_ready !== 1'b0) $display("FAIL rst_enq_ready got %b exp 0", enq_ready);
      else n_pass++;
      n_total++;
      reset_n = 1'b1;
      cyc();
      if (enq_ready !== 1'b1) $display("FAIL rel_enq_ready got %b exp 1", enq_ready);
      else n_pass++;
      n_total++;
   endtask

   task automatic test_fill();
      deq_ready = 1'b0;
      for (int i = 0; i < D; i++) begin
         enq_valid = 1'b1;
         enq_pc    = AW'(i * 4);
         enq_instr = $urandom;
         cyc();
      end
      if (count !== 3'd4) $display("FAIL fill_count got %0d exp 4", count);
      else n_pass++;
      n_total++;
      if (enq_ready !== 1'b0) $display("FAIL fill_ready got %b exp 0", enq_ready);
      else n_pass++;
      n_total++;
      if (deq_pc !== 12'h000) $display("FAIL fill_head got %h exp 000", deq_pc);
      else n_pass++;
      n_total++;
      enq_pc = 12'h010;
      enq_instr = $urandom;
      cyc();
      cyc();
      if (count !== 3'd4) $display("FAIL fill_refuse_count got %0d exp 4", count);
      else n_pass++;
      n_total++;
      drain();
   endtask

   task automatic test_stream();
      deq_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         enq_valid = 1'b1;
         enq_pc    = AW'(i * 4);
         enq_instr = $urandom;
         cyc();
         if (count !== (BYP ? 3'd0 : 3'd1)) $display("FAIL stream_count i=%0d got %0d exp %0d", i, count, BYP ? 0 : 1);
         else n_pass++;
         n_total++;
      end
      drain();
   endtask

   task automatic test_flush();
      deq_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         enq_valid = 1'b1;
         enq_pc    = AW'(12'h080 + i * 4);
         enq_instr = $urandom;
         cyc();
      end
      if (count !== 3'd3) $display("FAIL flush_pre_count got %0d exp 3", count);
      else n_pass++;
      n_total++;
      flush = 1'b1; enq_valid = 1'b1; enq_pc = 12'h100; enq_instr = $urandom; deq_ready = 1'b1;
      cyc();
      flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
      #1;
      if (count !== 3'd0) $display("FAIL flush_count got %0d exp 0", count);
      else n_pass++;
      n_total++;
      if (deq_valid !== 1'b0) $display("FAIL flush_deq_valid got %b exp 0", deq_valid);
      else n_pass++;
      n_total++;
      if (enq_ready !== 1'b1) $display("FAIL flush_enq_ready got %b exp 1", enq_ready);
      else n_pass++;
      n_total++;
      cyc();
      if (count !== 3'd0) $display("FAIL flush_lost got %0d exp 0", count);
      else n_pass++;
      n_total++;
   endtask

   task automatic test_full_deq();
      deq_ready = 1'b0;
      for (int i = 0; i < D; i++) begin
         enq_valid = 1'b1;
         enq_pc    = AW'(12'h300 + i * 4);
         enq_instr = $urandom;
         cyc();
      end
      enq_pc = 12'h200; enq_instr = $urandom; deq_ready = 1'b1;
      cyc();
      enq_valid = 1'b0; deq_ready = 1'b0;
      #1;
      if (count !== 3'd3) $display("FAIL fulldeq_count got %0d exp 3", count);
      else n_pass++;
      n_total++;
      if (deq_pc !== 12'h304) $display("FAIL fulldeq_head got %h exp 304", deq_pc);
      else n_pass++;
      n_total++;
      drain();
   endtask

   task automatic test_bypass();
      enq_valid = 1'b1; enq_pc = 12'h040; enq_instr = 32'h00500093; deq_ready = 1'b1;
      #1;
      if (deq_valid !== BYP) $display("FAIL byp_same_valid got %b exp %b", deq_valid, BYP);
      else n_pass++;
      n_total++;
      if (deq_pc !== (BYP ? 12'h040 : 12'h000)) $display("FAIL byp_same_pc got %h exp %h", deq_pc, BYP ? 12'h040 : 12'h000);
      else n_pass++;
      n_total++;
      if (deq_instr !== (BYP ? 32'h00500093 : 32'h0)) $display("FAIL byp_same_instr got %h", deq_instr);
      else n_pass++;
      n_total++;
      cyc();
      enq_valid = 1'b0; deq_ready = 1'b0;
      #1;
      if (count !== (BYP ? 3'd0 : 3'd1)) $display("FAIL byp_next_count got %0d exp %0d", count, BYP ? 0 : 1);
      else n_pass++;
      n_total++;
      if (deq_valid !== !BYP) $display("FAIL byp_next_valid got %b exp %b", deq_valid, !BYP);
      else n_pass++;
      n_total++;
      if (deq_pc !== (BYP ? 12'h000 : 12'h040)) $display("FAIL byp_next_pc got %h exp %h", deq_pc, BYP ? 12'h000 : 12'h040);
      else n_pass++;
      n_total++;
      drain();
   endtask

   task automatic test_mid_reset();
      deq_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         enq_valid = 1'b1;
         enq_pc    = AW'(12'h3E0 + i * 4);
         enq_instr = $urandom;
         cyc();
      end
      reset_n = 1'b0; enq_valid = 1'b1; enq_pc = 12'h3F0; deq_ready = 1'b1;
      cyc();
      if (count !== 3'd0) $display("FAIL midrst_count got %0d exp 0", count);
      else n_pass++;
      n_total++;
      if (deq_valid !== 1'b0) $display("FAIL midrst_valid got %b exp 0", deq_valid);
      else n_pass++;
      n_total++;
      reset_n = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0;
      cyc();
      if (count !== 3'd0) $display("FAIL midrst_rel_count got %0d exp 0", count);
      else n_pass++;
      n_total++;
      if (enq_ready !== 1'b1) $display("FAIL midrst_rel_ready got %b exp 1", enq_ready);
      else n_pass++;
      n_total++;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_stream();
      test_flush();
      test_full_deq();
      test_bypass();
      test_mid_reset();
      cyc();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
